mmio_unit: RTL and testbench
============================

Name: mmio_unit

Overview:
Parametrised memory-mapped I/O unit for the 16-bit core's data port. It generalises the core's fixed decode of keys, switches, hex display and LEDs into one block with a configurable base and widths. It adds what the core's inline I/O lacks: input synchronisers, sticky key-press edge capture with write-1-to-clear, and a programmable interval timer with a wrap flag and IRQ. It sits beside MemArray; the core muxes DOUT onto the data path when HIT=1.

Parameters:
DBITS, 16, data/address width
NKEYS, 4, number of push-button inputs (active-low, max DBITS-1)
NSW, 10, number of switch inputs
NLEDR, 10, red LED outputs
NLEDG, 8, green LED outputs
BASE, 16'hFFF0, byte address of 8-word register window (16-byte aligned)
TDIV, 50000, prescaler clocks per timer tick (>=1)

Ports:
CLK  in  1  system clock, all state on posedge
RESET_N  in  1  asynchronous active-low reset
ADDR  in  DBITS  byte address from core (bit 0 ignored)
WE  in  1  write strobe, qualified by HIT
DIN  in  DBITS  write data
DOUT  out  DBITS  read data, combinational from ADDR and registered state
HIT  out  1  ADDR[DBITS-1:4]==BASE[DBITS-1:4]
KEY  in  NKEYS  raw buttons, 0=pressed
SW  in  NSW  raw switches
HEXOUT  out  DBITS  value for SevenSeg digits
LEDR  out  NLEDR  red LEDs
LEDG  out  NLEDG  green LEDs
IRQ  out  1  OR of all capture/timer flags, registered

Behaviour:
- Register map, offset from BASE: +0 KDATA (R, synced KEY, zero-ext); +2 SDATA (R, synced SW); +4 STAT (R: bits[NKEYS-1:0] key-press flags, bit DBITS-1 timer flag; W: 1 clears bit); +6 TCNT (R/W); +8 HEX (R/W); +A LEDR (R/W, DIN[NLEDR-1:0]); +C LEDG (R/W, DIN[NLEDG-1:0]); +E TLIM (R/W).
- Reads: unused bits return 0; DOUT=0 when HIT=0. Read has no side effects.
- Writes: take effect on the posedge where WE=1 and HIT=1; visible to reads the next cycle. KDATA/SDATA writes are ignored.
- KEY/SW pass through 2-flop synchronisers. KDATA is valid 2 cycles after a pin change.
- Edge capture: flag[i] sets on the cycle synced KEY[i] goes 1->0. Release does not set it. The flag stays set until cleared by a W1C write. A new edge and a W1C of the same bit in the same cycle: set wins.
- Prescaler counts 0..TDIV-1 and pulses tick at TDIV-1, then wraps to 0.
- On tick: if TLIM!=0 and TCNT>=TLIM-1, then TCNT<=0 and tflag<=1. Otherwise TCNT<=TCNT+1, wrapping modulo 2^DBITS. TLIM=0 means free-running with no flag.
- A TCNT write beats a same-cycle tick, loads DIN, and resets the prescaler to 0.
- A TLIM write does not alter TCNT or the prescaler.
- tflag set and W1C in the same cycle: set wins.
- IRQ=|flags, registered one cycle after the flag changes.
- Reset (async assert, sync to CLK not required): HEXOUT=0, LEDR=0, LEDG=0, TCNT=0, TLIM=0, prescaler=0, all flags=0, IRQ=0.
- Reset values of synchronisers: KEY stages all-ones (released), so no spurious edge after reset; SW stages 0.
- Reset mid-operation: all state returns to reset values immediately. Pending flags are lost.

Decomposition:
- Shared package: register offset constants (OFF_KDATA..OFF_TLIM), STAT bit positions (STAT_TFLAG=DBITS-1).
- Sub-module mmio_sync_edge: parametrised width N, reset value RV, 2-flop synchroniser plus falling-edge pulse output. Instantiated once for KEY (RV all-ones, edge used) and once for SW (RV 0, edge unused).

Test Plan:
1. Reset with KEY=4'hF, SW=10'h2A5, then read +0 and +2 after 3 cycles -> 16'h000F, 16'h02A5; STAT=0; IRQ=0.
2. Write 16'h1234 to 16'hFFF8, 16'h3FF to FFFA, 16'hFF to FFFC -> HEXOUT=1234, LEDR=3FF, LEDG=FF next cycle; readback matches; a write to 16'h0FF8 leaves all unchanged with HIT=0.
3. Drive KEY[2] 1->0 and hold -> STAT=0004 three cycles later, IRQ=1 the next cycle; release, no change. W1C 0004 -> STAT=0, IRQ=0. Repeat with the edge on the same cycle as the W1C -> STAT stays 0004.
4. TDIV=4, TLIM=3 -> TCNT sequence 0,1,2,0 every 4 clocks; STAT bit15 sets on the wrap; TLIM=0 -> TCNT reaches FFFF then 0000 with no flag.
5. Write TCNT=16'h0010 on a tick cycle -> reads 0010, next increment 4 clocks later.
6. Assert RESET_N=0 mid-count with flags set -> all outputs 0 asynchronously; after release no key flag appears while KEY is held high.

Source files
------------

// File: rtl/mmio_unit_pkg.sv
// Shared constants for the memory-mapped I/O unit.
// Register offsets are byte offsets inside the 16-byte window.
package mmio_unit_pkg;

    localparam logic [3:0] OFF_KDATA = 4'h0;
    localparam logic [3:0] OFF_SDATA = 4'h2;
    localparam logic [3:0] OFF_STAT  = 4'h4;
    localparam logic [3:0] OFF_TCNT  = 4'h6;
    localparam logic [3:0] OFF_HEX   = 4'h8;
    localparam logic [3:0] OFF_LEDR  = 4'hA;
    localparam logic [3:0] OFF_LEDG  = 4'hC;
    localparam logic [3:0] OFF_TLIM  = 4'hE;

    // Timer flag lives in the top bit of STAT.
    function automatic int stat_tflag(input int dbits);
        return dbits - 1;
    endfunction

endpackage

// File: rtl/mmio_sync_edge.sv
// Two-flop input synchroniser with a falling-edge pulse
// taken from the synchronised value.
module mmio_sync_edge #(
    parameter int           N  = 4,
    parameter logic [N-1:0] RV = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q,
    output logic [N-1:0] o_fall
);

    logic [N-1:0] r_s1;
    logic [N-1:0] r_s2;
    logic [N-1:0] r_s3;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= RV;
            r_s2 <= RV;
            r_s3 <= RV;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_q    = r_s2;
    assign o_fall = r_s3 & ~r_s2;

endmodule

// File: rtl/mmio_unit.sv
// Memory-mapped I/O unit: keys, switches, hex/LED outputs,
// sticky key-press capture and an interval timer with IRQ.
module mmio_unit
    import mmio_unit_pkg::*;
#(
    parameter int               DBITS = 16,
    parameter int               NKEYS = 4,
    parameter int               NSW   = 10,
    parameter int               NLEDR = 10,
    parameter int               NLEDG = 8,
    parameter logic [DBITS-1:0] BASE  = 16'hFFF0,
    parameter int               TDIV  = 50000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [DBITS-1:0] ADDR,
    input  logic             WE,
    input  logic [DBITS-1:0] DIN,
    output logic [DBITS-1:0] DOUT,
    output logic             HIT,
    input  logic [NKEYS-1:0] KEY,
    input  logic [NSW-1:0]   SW,
    output logic [DBITS-1:0] HEXOUT,
    output logic [NLEDR-1:0] LEDR,
    output logic [NLEDG-1:0] LEDG,
    output logic             IRQ
);

    localparam int TF = stat_tflag(DBITS);
    localparam int PW = (TDIV > 1) ? $clog2(TDIV) : 1;
    localparam logic [PW-1:0]    PMAX = PW'(TDIV - 1);
    localparam logic [DBITS-1:0] ONE  = DBITS'(1);

    logic [NKEYS-1:0] w_key_q;
    logic [NKEYS-1:0] w_key_fall;
    logic [NSW-1:0]   w_sw_q;
    logic [NSW-1:0]   w_sw_fall_unused;
    logic             w_addr0_unused;
    logic [3:0]       w_off;
    logic             w_wr;
    logic             w_wr_stat;
    logic             w_wr_tcnt;
    logic             w_tick;
    logic             w_wrap;
    logic [NKEYS-1:0] w_kclr;
    logic [DBITS-1:0] w_stat;
    logic [DBITS-1:0] w_dout;

    logic [DBITS-1:0] r_hex;
    logic [NLEDR-1:0] r_ledr;
    logic [NLEDG-1:0] r_ledg;
    logic [DBITS-1:0] r_tcnt;
    logic [DBITS-1:0] r_tlim;
    logic [PW-1:0]    r_pre;
    logic [NKEYS-1:0] r_kflag;
    logic             r_tflag;
    logic             r_irq;

    // Keys idle high, so their synchroniser resets to released.
    mmio_sync_edge #(.N(NKEYS), .RV({NKEYS{1'b1}})) u_key_sync (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_d     (KEY),
        .o_q     (w_key_q),
        .o_fall  (w_key_fall)
    );

    mmio_sync_edge #(.N(NSW), .RV({NSW{1'b0}})) u_sw_sync (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_d     (SW),
        .o_q     (w_sw_q),
        .o_fall  (w_sw_fall_unused)
    );

    assign w_addr0_unused = ADDR[0];
    assign HIT       = (ADDR[DBITS-1:4] == BASE[DBITS-1:4]);
    assign w_off     = {ADDR[3:1], 1'b0};
    assign w_wr      = WE & HIT;
    assign w_wr_stat = w_wr && (w_off == OFF_STAT);
    assign w_wr_tcnt = w_wr && (w_off == OFF_TCNT);
    assign w_kclr    = w_wr_stat ? DIN[NKEYS-1:0] : '0;
    assign w_tick    = (r_pre == PMAX);
    assign w_wrap    = (r_tlim != '0) && (r_tcnt >= r_tlim - ONE);

    always_comb begin
        w_stat = '0;
        w_stat[NKEYS-1:0] = r_kflag;
        w_stat[TF] = r_tflag;
    end

    always_comb begin
        w_dout = '0;
        if (HIT) begin
            unique case (1'b1)
                w_off == OFF_KDATA: w_dout[NKEYS-1:0] = w_key_q;
                w_off == OFF_SDATA: w_dout[NSW-1:0]   = w_sw_q;
                w_off == OFF_STAT:  w_dout            = w_stat;
                w_off == OFF_TCNT:  w_dout            = r_tcnt;
                w_off == OFF_HEX:   w_dout            = r_hex;
                w_off == OFF_LEDR:  w_dout[NLEDR-1:0] = r_ledr;
                w_off == OFF_LEDG:  w_dout[NLEDG-1:0] = r_ledg;
                default:            w_dout            = r_tlim;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hex  <= '0;
            r_ledr <= '0;
            r_ledg <= '0;
            r_tlim <= '0;
        end else if (w_wr) begin
            if (w_off == OFF_HEX)  r_hex  <= DIN;
            if (w_off == OFF_LEDR) r_ledr <= DIN[NLEDR-1:0];
            if (w_off == OFF_LEDG) r_ledg <= DIN[NLEDG-1:0];
            if (w_off == OFF_TLIM) r_tlim <= DIN;
        end
    end

    // A TCNT load overrides a coincident tick and restarts the prescaler.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pre  <= '0;
            r_tcnt <= '0;
        end else if (w_wr_tcnt) begin
            r_pre  <= '0;
            r_tcnt <= DIN;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) r_tcnt <= w_wrap ? '0 : r_tcnt + ONE;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_kflag <= '0;
            r_tflag <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_kflag <= (r_kflag & ~w_kclr) | w_key_fall;
            r_tflag <= (r_tflag & ~(w_wr_stat & DIN[TF]))
                     | (w_tick & w_wrap & ~w_wr_tcnt);
            r_irq   <= (|r_kflag) | r_tflag;
        end
    end

    assign DOUT   = w_dout;
    assign HEXOUT = r_hex;
    assign LEDR   = r_ledr;
    assign LEDG   = r_ledg;
    assign IRQ    = r_irq;

endmodule

// File: tb/tb_mmio_unit.sv
// Directed bench for mmio_unit: register table plus
// hand-timed key capture, timer and reset sequences.
module tb_mmio_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [15:0] ADDR;
    logic        WE;
    logic [15:0] DIN;
    logic [15:0] DOUT;
    logic        HIT;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [15:0] HEXOUT;
    logic [9:0]  LEDR;
    logic [7:0]  LEDG;
    logic        IRQ;

    int n_cmp = 0;
    int n_err = 0;

    mmio_unit #(.TDIV(4)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .ADDR    (ADDR),
        .WE      (WE),
        .DIN     (DIN),
        .DOUT    (DOUT),
        .HIT     (HIT),
        .KEY     (KEY),
        .SW      (SW),
        .HEXOUT  (HEXOUT),
        .LEDR    (LEDR),
        .LEDG    (LEDG),
        .IRQ     (IRQ)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] din;
        logic        hit;
        logic [15:0] dout;
        string       name;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        DIN  = d;
        WE   = 1'b1;
        @(posedge CLK);
        #1;
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp,
                      input string nm);
        ADDR = a;
        WE   = 1'b0;
        #1;
        chk(nm, DOUT, exp);
    endtask

    initial begin
        tbl[0]  = '{16'hFFF8, 1'b1, 16'h1234, 1'b1, 16'h0000, "wr_hex"};
        tbl[1]  = '{16'hFFFA, 1'b1, 16'h03FF, 1'b1, 16'h0000, "wr_ledr"};
        tbl[2]  = '{16'hFFFC, 1'b1, 16'h00FF, 1'b1, 16'h0000, "wr_ledg"};
        tbl[3]  = '{16'hFFF8, 1'b0, 16'h0000, 1'b1, 16'h1234, "rd_hex"};
        tbl[4]  = '{16'hFFFA, 1'b0, 16'h0000, 1'b1, 16'h03FF, "rd_ledr"};
        tbl[5]  = '{16'hFFFC, 1'b0, 16'h0000, 1'b1, 16'h00FF, "rd_ledg"};
        tbl[6]  = '{16'h0FF8, 1'b1, 16'hDEAD, 1'b0, 16'h0000, "wr_miss"};
        tbl[7]  = '{16'h0FF8, 1'b0, 16'h0000, 1'b0, 16'h0000, "rd_miss"};
        tbl[8]  = '{16'hFFF8, 1'b0, 16'h0000, 1'b1, 16'h1234, "rd_hex2"};
        tbl[9]  = '{16'hFFFB, 1'b1, 16'hFFFF, 1'b1, 16'h0000, "wr_ledr_odd"};
        tbl[10] = '{16'hFFFA, 1'b0, 16'h0000, 1'b1, 16'h03FF, "rd_ledr_mask"};
        tbl[11] = '{16'hFFF0, 1'b1, 16'h5555, 1'b1, 16'h0000, "wr_kdata"};
        tbl[12] = '{16'hFFF0, 1'b0, 16'h0000, 1'b1, 16'h000F, "rd_kdata"};
        tbl[13] = '{16'hFFFC, 1'b1, 16'h0A5C, 1'b1, 16'h0000, "wr_ledg2"};
        tbl[14] = '{16'hFFFC, 1'b0, 16'h0000, 1'b1, 16'h005C, "rd_ledg2"};

        // Reset state
        RESET_N = 1'b0;
        ADDR = 16'h0000;
        WE = 1'b0;
        DIN = 16'h0000;
        KEY = 4'hF;
        SW = 10'h2A5;
        tick(2);
        chk("rst_irq", IRQ, 16'h0);
        chk("rst_hex", HEXOUT, 16'h0);
        RESET_N = 1'b1;
        tick(3);
        rd(16'hFFF0, 16'h000F, "kdata");
        rd(16'hFFF2, 16'h02A5, "sdata");
        rd(16'hFFF4, 16'h0000, "stat0");
        chk("irq0", IRQ, 16'h0);

        // Register table
        tick(1);
        for (int i = 0; i < NV; i++) begin
            ADDR = tbl[i].addr;
            WE   = tbl[i].we;
            DIN  = tbl[i].din;
            #1;
            chk({tbl[i].name, "_hit"}, HIT, tbl[i].hit);
            if (!tbl[i].we) chk(tbl[i].name, DOUT, tbl[i].dout);
            @(posedge CLK);
            #1;
            WE = 1'b0;
        end
        chk("hexout", HEXOUT, 16'h1234);
        chk("ledr", LEDR, 16'h03FF);
        chk("ledg", LEDG, 16'h005C);

        // Key press capture
        KEY = 4'hB;
        tick(2);
        rd(16'hFFF0, 16'h000B, "kdata_sync");
        rd(16'hFFF4, 16'h0000, "stat_early");
        tick(1);
        rd(16'hFFF4, 16'h0004, "stat_key2");
        chk("irq_lag", IRQ, 16'h0);
        tick(1);
        chk("irq_key", IRQ, 16'h1);
        wr(16'hFFF4, 16'h0001);
        rd(16'hFFF4, 16'h0004, "w1c_other");
        wr(16'hFFF4, 16'h0004);
        rd(16'hFFF4, 16'h0000, "w1c_key2");
        tick(1);
        chk("irq_clr", IRQ, 16'h0);
        KEY = 4'hF;
        tick(4);
        rd(16'hFFF4, 16'h0000, "release");

        // Edge and W1C on the same clock
        KEY = 4'hB;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        wr(16'hFFF4, 16'h0004);
        rd(16'hFFF4, 16'h0004, "set_wins");
        KEY = 4'hF;
        tick(3);
        wr(16'hFFF4, 16'h0004);
        tick(1);
        rd(16'hFFF4, 16'h0000, "stat_clr2");
        chk("irq_clr2", IRQ, 16'h0);

        // Timer with TLIM=3
        wr(16'hFFFE, 16'h0003);
        wr(16'hFFF6, 16'h0000);
        rd(16'hFFF6, 16'h0000, "tcnt_ld");
        tick(3);
        rd(16'hFFF6, 16'h0000, "tcnt_pre3");
        tick(1);
        rd(16'hFFF6, 16'h0001, "tcnt_1");
        tick(4);
        rd(16'hFFF6, 16'h0002, "tcnt_2");
        rd(16'hFFF4, 16'h0000, "tflag_pre");
        tick(4);
        rd(16'hFFF6, 16'h0000, "tcnt_wrap");
        rd(16'hFFF4, 16'h8000, "tflag");
        chk("irq_tlag", IRQ, 16'h0);
        tick(1);
        chk("irq_t", IRQ, 16'h1);
        wr(16'hFFF4, 16'h8000);
        rd(16'hFFF4, 16'h0000, "tflag_clr");
        wr(16'hFFFE, 16'h0000);
        rd(16'hFFFE, 16'h0000, "tlim0");
        chk("irq_tclr", IRQ, 16'h0);

        // Free-running rollover
        wr(16'hFFF6, 16'hFFFE);
        rd(16'hFFF6, 16'hFFFE, "tcnt_fffe");
        tick(4);
        rd(16'hFFF6, 16'hFFFF, "tcnt_ffff");
        tick(4);
        rd(16'hFFF6, 16'h0000, "tcnt_roll");
        rd(16'hFFF4, 16'h0000, "no_tflag");

        // TCNT load landing on a tick
        tick(3);
        wr(16'hFFF6, 16'h0010);
        rd(16'hFFF6, 16'h0010, "ld_on_tick");
        tick(3);
        rd(16'hFFF6, 16'h0010, "ld_hold");
        tick(1);
        rd(16'hFFF6, 16'h0011, "ld_inc");

        // Asynchronous reset with a flag pending
        KEY = 4'hE;
        tick(3);
        rd(16'hFFF4, 16'h0001, "stat_key0");
        tick(1);
        chk("irq_key0", IRQ, 16'h1);
        #2;
        RESET_N = 1'b0;
        KEY = 4'hF;
        #1;
        chk("arst_irq", IRQ, 16'h0);
        chk("arst_hex", HEXOUT, 16'h0);
        chk("arst_ledr", LEDR, 16'h0);
        chk("arst_ledg", LEDG, 16'h0);
        rd(16'hFFF4, 16'h0000, "arst_stat");
        rd(16'hFFF6, 16'h0000, "arst_tcnt");
        tick(2);
        RESET_N = 1'b1;
        tick(5);
        rd(16'hFFF4, 16'h0000, "post_rst_stat");
        rd(16'hFFF0, 16'h000F, "post_rst_key");
        chk("post_rst_irq", IRQ, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
